// File: rtl/timer_sched_pkg.sv
// Shared types for the timer scheduler.
// Optional abort input is enabled with TIMER_SCHED_ABORT_EN.
package timer_sched_pkg;

    localparam int MAX_REQ = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        COUNT = 1'b1
    } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin pick starting one past the last winner.
// Used by timer_scheduler; no state of its own.
module rr_arbiter
    import timer_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int IW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IW-1:0]      last_winner,
    output logic [NUM_REQ-1:0] gnt_onehot,
    output logic [IW-1:0]      idx,
    output logic               valid
);

    int j;

    always_comb begin
        gnt_onehot = '0;
        idx        = '0;
        valid      = |req;
        j          = 0;
        // Walk downward so the closest requester after last_winner wins.
        for (int i = NUM_REQ; i >= 1; i--) begin
            j = int'(last_winner) + i;
            if (j >= NUM_REQ) begin
                j = j - NUM_REQ;
            end
            if (req[j]) begin
                idx = IW'(j);
            end
        end
        gnt_onehot[idx] = valid;
    end

endmodule

// File: rtl/timer_scheduler.sv
// Round-robin timer scheduler: grants one requester, counts its cycles.
// Define TIMER_SCHED_ABORT_EN to add the abort input.
module timer_scheduler
    import timer_sched_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32
) (
    input  logic                     clk,
    input  logic                     rst,
`ifdef TIMER_SCHED_ABORT_EN
    input  logic                     abort,
`endif
    input  logic [NUM_REQ-1:0]       req,
    input  logic [NUM_REQ*WIDTH-1:0] cycles,
    output logic [NUM_REQ-1:0]       gnt,
    output logic [NUM_REQ-1:0]       done,
    output logic                     busy
);

    localparam int IW = $clog2(NUM_REQ);

    state_t             state_q, state_d;
    logic [IW-1:0]      win_q, win_d;
    logic [IW-1:0]      lw_q, lw_d;
    logic [WIDTH-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   cyc_q, cyc_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic [NUM_REQ-1:0] done_q, done_d;

    logic [NUM_REQ-1:0] arb_oh;
    logic [IW-1:0]      arb_idx;
    logic               arb_valid;
    logic [WIDTH-1:0]   sel_cyc;
    logic [WIDTH-1:0]   cyc_eff;
    logic [WIDTH-1:0]   cnt_inc;
    logic [NUM_REQ-1:0] win_oh;
    logic               abort_i;

`ifdef TIMER_SCHED_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IW      (IW)
    ) u_arb (
        .req         (req),
        .last_winner (lw_q),
        .gnt_onehot  (arb_oh),
        .idx         (arb_idx),
        .valid       (arb_valid)
    );

    assign sel_cyc = cycles[int'(arb_idx)*WIDTH +: WIDTH];
    // A zero request behaves as a one-cycle timing.
    assign cyc_eff = (sel_cyc == '0) ? WIDTH'(1) : sel_cyc;
    assign cnt_inc = cnt_q + WIDTH'(1);
    assign win_oh  = NUM_REQ'(1) << win_q;

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        lw_d    = lw_q;
        cnt_d   = cnt_q;
        cyc_d   = cyc_q;
        gnt_d   = '0;
        done_d  = '0;
        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    state_d = COUNT;
                    win_d   = arb_idx;
                    lw_d    = arb_idx;
                    cyc_d   = cyc_eff;
                    cnt_d   = WIDTH'(1);
                    gnt_d   = arb_oh;
                    if (cyc_eff == WIDTH'(1)) begin
                        done_d = arb_oh;
                    end
                end
            end
            COUNT: begin
                // Completion takes priority over abort.
                if (cnt_q == cyc_q) begin
                    state_d = IDLE;
                end else if (abort_i) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == cyc_q) begin
                        done_d = win_oh;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            win_q   <= '0;
            lw_q    <= IW'(NUM_REQ - 1);
            cnt_q   <= '0;
            cyc_q   <= '0;
            gnt_q   <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            lw_q    <= lw_d;
            cnt_q   <= cnt_d;
            cyc_q   <= cyc_d;
            gnt_q   <= gnt_d;
            done_q  <= done_d;
        end
    end

    assign gnt  = gnt_q;
    assign done = done_q;
    assign busy = (state_q == COUNT);

endmodule

// File: tb/tb_timer_scheduler.sv
// Self-checking bench for timer_scheduler: directed cases plus random
// traffic compared against a grant/done schedule model.
module tb_timer_scheduler;

    localparam int N = 4;
    localparam int W = 32;

    logic             clk = 1'b0;
    logic             rst;
    logic             abort;
    logic [N-1:0]     req;
    logic [N*W-1:0]   cycles;
    logic [N-1:0]     gnt;
    logic [N-1:0]     done;
    logic             busy;

    always #5 clk = ~clk;

    timer_scheduler #(
        .NUM_REQ (N),
        .WIDTH   (W)
    ) dut (
        .clk    (clk),
        .rst    (rst),
`ifdef TIMER_SCHED_ABORT_EN
        .abort  (abort),
`endif
        .req    (req),
        .cycles (cycles),
        .gnt    (gnt),
        .done   (done),
        .busy   (busy)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int t        = 0;

    // Schedule model: edge of grant, edge of done, last busy edge.
    int g_t    = -10;
    int d_t    = -10;
    int e_t    = -10;
    int m_win  = 0;
    int m_last = N - 1;
    int cyc_arr[N];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at edge %0d",
                     name, act, exp, t);
        end
    endtask

    task automatic model_edge();
        int w;
        int c;
        int j;
        w = -1;
        c = 0;
        if (rst) begin
            g_t    = -10;
            d_t    = -10;
            e_t    = -10;
            m_last = N - 1;
        end else begin
            if (abort && g_t <= t - 1 && t - 1 <= e_t && t - 1 != d_t) begin
                e_t = t - 1;
                d_t = -10;
            end
            if (t >= e_t + 2 && req != '0) begin
                for (int i = 1; i <= N; i++) begin
                    j = (m_last + i) % N;
                    if (w < 0 && req[j]) w = j;
                end
                c = int'(cycles[w*W +: W]);
                if (c == 0) c = 1;
                g_t    = t;
                d_t    = t + c - 1;
                e_t    = d_t;
                m_win  = w;
                m_last = w;
            end
        end
    endtask

    task automatic step(input logic r, input logic [N-1:0] rq,
                        input logic ab);
        logic [N-1:0] eg;
        logic [N-1:0] ed;
        logic         eb;
        rst   = r;
        req   = rq;
        abort = ab;
        for (int i = 0; i < N; i++) begin
            cycles[i*W +: W] = W'(cyc_arr[i]);
        end
        @(posedge clk);
        t++;
        model_edge();
        #1;
        eg = (t == g_t) ? N'(1) << m_win : '0;
        ed = (t == d_t) ? N'(1) << m_win : '0;
        eb = (g_t <= t) && (t <= e_t);
        check("model_gnt", 32'(gnt), 32'(eg));
        check("model_done", 32'(done), 32'(ed));
        check("model_busy", 32'(busy), 32'(eb));
    endtask

    initial begin
        logic [N-1:0] rq;
        logic         ab;
        logic         r;
        for (int i = 0; i < N; i++) cyc_arr[i] = 3;
        rst    = 1'b1;
        abort  = 1'b0;
        req    = '0;
        cycles = '0;

        // Reset state
        step(1'b1, 4'b0000, 1'b0);
        step(1'b1, 4'b0000, 1'b0);
        check("reset_gnt", 32'(gnt), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);

        // Single requester 2, five cycles
        cyc_arr[2] = 5;
        step(1'b0, 4'b0100, 1'b0);
        check("r2_gnt", 32'(gnt), 32'h4);
        check("r2_busy1", 32'(busy), 32'h1);
        for (int k = 2; k <= 4; k++) begin
            step(1'b0, 4'b0000, 1'b0);
            check("r2_nodone", 32'(done), 32'h0);
        end
        step(1'b0, 4'b0000, 1'b0);
        check("r2_done5", 32'(done), 32'h4);
        check("r2_busy5", 32'(busy), 32'h1);
        step(1'b0, 4'b0000, 1'b0);
        check("r2_idle6", 32'(busy), 32'h0);

        // All four requesting, three cycles each
        step(1'b1, 4'b0000, 1'b0);
        for (int i = 0; i < N; i++) cyc_arr[i] = 3;
        for (int k = 1; k <= 17; k++) begin
            step(1'b0, 4'b1111, 1'b0);
            check("rr_gnt", 32'(gnt),
                  ((k - 1) % 4 == 0) ? 32'(1) << (((k - 1) / 4) % 4) : 32'h0);
            check("rr_done", 32'(done),
                  ((k - 1) % 4 == 2) ? 32'(1) << (((k - 1) / 4) % 4) : 32'h0);
        end

        // Zero cycles: gnt and done together
        step(1'b1, 4'b0000, 1'b0);
        cyc_arr[1] = 0;
        step(1'b0, 4'b0010, 1'b0);
        check("z_gnt", 32'(gnt), 32'h2);
        check("z_done", 32'(done), 32'h2);
        step(1'b0, 4'b0000, 1'b0);
        check("z_idle", 32'(busy), 32'h0);

        // Reset in the middle of a count
        cyc_arr[2] = 10;
        step(1'b0, 4'b0100, 1'b0);
        step(1'b0, 4'b0000, 1'b0);
        step(1'b0, 4'b0000, 1'b0);
        step(1'b1, 4'b0000, 1'b0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        step(1'b0, 4'b1111, 1'b0);
        check("rst_next", 32'(gnt), 32'h1);

        // Cycles change during a count is ignored
        step(1'b1, 4'b0000, 1'b0);
        cyc_arr[0] = 6;
        step(1'b0, 4'b0001, 1'b0);
        cyc_arr[0] = 2;
        step(1'b0, 4'b0001, 1'b0);
        check("chg_early", 32'(done), 32'h0);
        for (int k = 3; k <= 5; k++) step(1'b0, 4'b0001, 1'b0);
        step(1'b0, 4'b0001, 1'b0);
        check("chg_done6", 32'(done), 32'h1);

`ifdef TIMER_SCHED_ABORT_EN
        step(1'b1, 4'b0000, 1'b0);
        cyc_arr[3] = 8;
        step(1'b0, 4'b1000, 1'b0);
        for (int k = 2; k <= 4; k++) step(1'b0, 4'b0000, 1'b0);
        step(1'b0, 4'b0000, 1'b1);
        check("ab_busy", 32'(busy), 32'h0);
        check("ab_done", 32'(done), 32'h0);
        step(1'b0, 4'b1000, 1'b0);
        check("ab_regnt", 32'(gnt), 32'h8);
        for (int k = 2; k <= 8; k++) step(1'b0, 4'b0000, 1'b0);
        check("ab_done8", 32'(done), 32'h8);
        step(1'b0, 4'b0000, 1'b1);
        check("ab_end", 32'(busy), 32'h0);
`endif

        // Random traffic against the schedule model
        step(1'b1, 4'b0000, 1'b0);
        for (int k = 0; k < 3000; k++) begin
            for (int i = 0; i < N; i++) begin
                if ($urandom_range(0, 3) == 0) cyc_arr[i] = $urandom_range(0, 6);
            end
            r  = ($urandom_range(0, 99) == 0);
            rq = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
`ifdef TIMER_SCHED_ABORT_EN
            ab = ($urandom_range(0, 19) == 0);
`else
            ab = 1'b0;
`endif
            step(r, rq, ab);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
